// File: rtl/matvec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matvec_pkg
// Brief    : Shared types and width/saturation helpers for the matvec stages.
// Revision : 1.0 - initial release
// ============================================================================
package matvec_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } rq_state_t;

   function automatic int y_width(input int w_x, input int w_k, input int c);
      return w_x + w_k + $clog2(c);
   endfunction

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/requant_lane.sv
`default_nettype none
// ============================================================================
// Module   : requant_lane
// Brief    : Combinational round-shift, optional ReLU and saturation for one lane.
// Revision : 1.0 - initial release
// ============================================================================
module requant_lane
   import matvec_pkg::*;
#(
   parameter int W_Y   = 19,
   parameter int W_O   = 8,
   parameter int SHIFT = 8,
   parameter int RELU  = 1
)(
   input  logic [W_Y-1:0] y,
   output logic [W_O-1:0] q
);

   localparam int                c_RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [W_Y:0] c_RND  = (SHIFT > 0) ? ((W_Y+1)'(1) << c_RND_SH) : '0;
   localparam logic signed [W_Y:0] c_MAX  = (W_Y+1)'(sat_max(W_O));
   localparam logic signed [W_Y:0] c_MIN  = (W_Y+1)'(sat_min(W_O));

   logic signed [W_Y:0] w_t;
   logic signed [W_Y:0] w_sh;
   logic signed [W_Y:0] w_r;

   // One extra bit of headroom keeps the rounding add from wrapping.
   always_comb begin
      w_t  = $signed({y[W_Y-1], y}) + c_RND;
      w_sh = w_t >>> SHIFT;
      w_r  = ((RELU != 0) && w_sh[W_Y]) ? '0 : w_sh;
      if (w_r > c_MAX) begin
         q = c_MAX[W_O-1:0];
      end else if (w_r < c_MIN) begin
         q = c_MIN[W_O-1:0];
      end else begin
         q = w_r[W_O-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/matvec_requant_ser.sv
`default_nettype none
// ============================================================================
// Module   : matvec_requant_ser
// Brief    : Captures an R-lane sum vector, requantizes it, streams one lane per beat.
// Revision : 1.0 - initial release
// ============================================================================
module matvec_requant_ser
   import matvec_pkg::*;
#(
   parameter int R     = 8,
   parameter int W_Y   = y_width(8, 8, 8),
   parameter int W_O   = 8,
   parameter int SHIFT = 8,
   parameter int RELU  = 1,
   parameter int IW    = (R > 1) ? $clog2(R) : 1
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [R*W_Y-1:0] s_y,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [W_O-1:0]   m_data,
   output logic [IW-1:0]    m_index,
   output logic             m_last
);

   localparam logic [IW-1:0] c_LAST = IW'(R - 1);

   rq_state_t             r_state;
   rq_state_t             w_state_nxt;
   logic [R-1:0][W_O-1:0] w_q;
   logic [R-1:0][W_O-1:0] r_buf;
   logic [W_O-1:0]        r_data;
   logic [IW-1:0]         r_index;
   logic [IW-1:0]         w_index_inc;
   logic                  w_capture;
   logic                  w_beat;
   logic                  w_last;

   for (genvar g = 0; g < R; g++) begin : g_lane
      requant_lane #(
         .W_Y   (W_Y),
         .W_O   (W_O),
         .SHIFT (SHIFT),
         .RELU  (RELU)
      ) u_lane (
         .y (s_y[g*W_Y +: W_Y]),
         .q (w_q[g])
      );
   end

   assign w_last      = (r_index == c_LAST);
   assign w_capture   = s_valid & s_ready;
   assign w_beat      = m_valid & m_ready;
   assign w_index_inc = r_index + IW'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A capture always lands on an idle cycle or on the final beat, so it wins.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_capture) w_state_nxt = SEND;
         SEND:    if (w_beat && w_last && !w_capture) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      case (r_state)
         IDLE:    s_ready = rstn;
         SEND: begin
            m_valid = 1'b1;
            s_ready = m_ready & w_last;
         end
         default: s_ready = 1'b0;
      endcase
   end

   // Element 0 goes straight to the output register so it is visible right after capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_buf   <= '0;
         r_data  <= '0;
         r_index <= '0;
      end else if (w_capture) begin
         r_buf   <= w_q;
         r_data  <= w_q[0];
         r_index <= '0;
      end else if (w_beat) begin
         if (w_last) begin
            r_index <= '0;
         end else begin
            r_index <= w_index_inc;
            r_data  <= r_buf[w_index_inc];
         end
      end
   end

   assign m_data  = r_data;
   assign m_index = r_index;
   assign m_last  = m_valid & w_last;

endmodule
`default_nettype wire

// File: tb/tb_matvec_requant_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_matvec_requant_ser
// Brief    : Three configurations driven in lockstep and checked against a lane-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matvec_requant_ser;
   import matvec_pkg::*;

   localparam int R   = 8;
   localparam int W_Y = 19;
   localparam int W_O = 8;

   logic             clk     = 1'b0;
   logic             rstn    = 1'b0;
   logic             s_valid = 1'b0;
   logic             m_ready = 1'b1;
   logic [R*W_Y-1:0] s_y     = '0;

   logic s_ready_a, m_valid_a, m_last_a;
   logic s_ready_b, m_valid_b, m_last_b;
   logic s_ready_c, m_valid_c, m_last_c;
   logic [W_O-1:0] m_data_a, m_data_b;
   logic [W_Y-1:0] m_data_c;
   logic [2:0]     m_index_a, m_index_b, m_index_c;

   always #5 clk = ~clk;

   matvec_requant_ser #(.R(R), .W_Y(W_Y), .W_O(W_O), .SHIFT(8), .RELU(1)) dut_a (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_a), .s_y(s_y),
      .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_index(m_index_a), .m_last(m_last_a));

   matvec_requant_ser #(.R(R), .W_Y(W_Y), .W_O(W_O), .SHIFT(8), .RELU(0)) dut_b (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_b), .s_y(s_y),
      .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_index(m_index_b), .m_last(m_last_b));

   matvec_requant_ser #(.R(R), .W_Y(W_Y), .W_O(W_Y), .SHIFT(0), .RELU(0)) dut_c (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_c), .s_y(s_y),
      .m_valid(m_valid_c), .m_ready(m_ready), .m_data(m_data_c), .m_index(m_index_c), .m_last(m_last_c));

   typedef struct {
      int     idx;
      longint da;
      longint db;
      longint dc;
   } elem_t;

   elem_t  exp_q[$];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     beats   = 0;
   longint vec [R];
   bit     rand_on = 1'b0;

   function automatic longint ref_rq(input longint y, input int sh, input int relu, input int wo);
      longint t, hi, lo;
      t = y;
      if (sh > 0) t = t + (longint'(1) << (sh - 1));
      t  = t >>> sh;
      if (relu != 0 && t < 0) t = 0;
      hi = (longint'(1) << (wo - 1)) - 1;
      lo = -hi - 1;
      if (t > hi) t = hi;
      else if (t < lo) t = lo;
      return t;
   endfunction

   function automatic longint lane(input int i);
      logic signed [W_Y-1:0] v;
      v = s_y[i*W_Y +: W_Y];
      return longint'(v);
   endfunction

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: compares, then advances the model to what the coming edge must do.
   always @(negedge clk) begin
      logic exp_v, exp_sr, cap, bt;
      if (!rstn) begin
         exp_q.delete();
         chk("rst_m_valid", m_valid_a, 0);
         chk("rst_s_ready", s_ready_a, 0);
         chk("rst_m_index", m_index_a, 0);
         chk("rst_m_last", m_last_a, 0);
         chk("rst_m_data", $signed(m_data_a), 0);
         chk("rst_m_valid_b", m_valid_b, 0);
         chk("rst_m_valid_c", m_valid_c, 0);
      end else begin
         exp_v  = (exp_q.size() > 0);
         exp_sr = !exp_v || (exp_q.size() == 1 && m_ready);
         chk("m_valid", m_valid_a, exp_v);
         chk("m_valid_b", m_valid_b, exp_v);
         chk("m_valid_c", m_valid_c, exp_v);
         chk("s_ready", s_ready_a, exp_sr);
         chk("s_ready_b", s_ready_b, exp_sr);
         chk("s_ready_c", s_ready_c, exp_sr);
         if (exp_v) begin
            chk("m_index", m_index_a, exp_q[0].idx);
            chk("m_last", m_last_a, exp_q[0].idx == R - 1);
            chk("m_data_relu", $signed(m_data_a), exp_q[0].da);
            chk("m_data_norelu", $signed(m_data_b), exp_q[0].db);
            chk("m_data_ident", $signed(m_data_c), exp_q[0].dc);
            chk("m_index_c", m_index_c, exp_q[0].idx);
         end
         cap = s_valid && exp_sr;
         bt  = exp_v && m_ready;
         if (bt) begin
            void'(exp_q.pop_front());
            beats++;
         end
         if (cap) begin
            for (int i = 0; i < R; i++) begin
               exp_q.push_back('{i, ref_rq(lane(i), 8, 1, W_O), ref_rq(lane(i), 8, 0, W_O),
                                 ref_rq(lane(i), 0, 0, W_Y)});
            end
         end
      end
   end

   task automatic push();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < R; i++) s_y[i*W_Y +: W_Y] = W_Y'(vec[i]);
      s_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (s_ready_a) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: s_ready stayed 0, required 1");
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!m_valid_a && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: m_valid stayed %0d, required 0", m_valid_a);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_vec();
      logic signed [W_Y-1:0] tmp;
      for (int i = 0; i < R; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            vec[i] = longint'($urandom_range(0, 2000)) - 1000;
         end else begin
            tmp    = W_Y'($urandom);
            vec[i] = longint'(tmp);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      longint t1, t2;
      int     b0;

      chk("model_384_relu", ref_rq(384, 8, 1, 8), 2);
      chk("model_m384", ref_rq(-384, 8, 0, 8), -1);
      chk("model_127", ref_rq(127, 8, 0, 8), 0);
      chk("model_128", ref_rq(128, 8, 0, 8), 1);
      chk("model_100000", ref_rq(100000, 8, 0, 8), 127);
      chk("model_m100000", ref_rq(-100000, 8, 0, 8), -128);
      chk("model_m100000_relu", ref_rq(-100000, 8, 1, 8), 0);
      chk("model_ident", ref_rq(-262144, 0, 0, 19), -262144);

      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Single vector, element 0 visible right after capture
      vec    = '{default: 0};
      vec[0] = 384;
      push();
      chk("t1_data0", $signed(m_data_a), 2);
      chk("t1_index0", m_index_a, 0);
      chk("t1_valid", m_valid_a, 1);
      wait_idle();

      vec = '{-384, 127, 128, 100000, -100000, 384, 0, -1};
      push();
      chk("t2_norelu_lane0", $signed(m_data_b), -1);
      chk("t2_relu_lane0", $signed(m_data_a), 0);
      wait_idle();

      // Stall while index 3 is presented
      rand_vec();
      push();
      repeat (3) @(posedge clk);
      #1;
      chk("t3_index3", m_index_a, 3);
      m_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t3_hold_index", m_index_a, 3);
         chk("t3_hold_s_ready", s_ready_a, 0);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      wait_idle();

      // Back-to-back vectors without a bubble
      b0 = beats;
      rand_vec();
      push();
      t1 = longint'($time);
      rand_vec();
      push();
      t2 = longint'($time);
      chk("t4_capture_gap_cycles", (t2 - t1) / 10, 8);
      wait_idle();
      chk("t4_beats", beats - b0, 16);

      // Asynchronous reset in mid-stream
      rand_vec();
      push();
      repeat (5) @(posedge clk);
      #1;
      chk("t5_index5", m_index_a, 5);
      #2;
      rstn = 1'b0;
      #1;
      chk("t5_async_valid", m_valid_a, 0);
      chk("t5_async_valid_b", m_valid_b, 0);
      chk("t5_async_s_ready", s_ready_a, 0);
      chk("t5_async_index", m_index_a, 0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_idle_s_ready", s_ready_a, 1);
      chk("t5_idle_valid", m_valid_a, 0);
      rand_vec();
      push();
      chk("t5_restart_index", m_index_a, 0);
      chk("t5_restart_valid", m_valid_a, 1);
      wait_idle();

      // Random traffic with random back-pressure
      rand_on = 1'b1;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               rand_vec();
               push();
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 12)) @(posedge clk);
                  #1;
               end
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      m_ready = 1'b1;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
